// File: rtl/ws281x_stream.sv
// WS281x LED strip driver: a small pixel FIFO feeding a one-wire NRZ serialiser
// with per-pixel repeat count and optional latch (reset) pulse.
module ws281x_stream #(
  parameter int CLOCK_MHZ = 64,
  parameter int BITS      = 24,
  parameter int DEPTH     = 4,
  parameter int T0H_NS    = 400,
  parameter int T1H_NS    = 800,
  parameter int PERIOD_NS = 1250,
  parameter int RESET_US  = 325
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BITS-1:0]          data_in,
  input  logic [7:0]               repeat_in,
  input  logic                     latch,
  input  logic                     valid,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     led
);

  localparam int unsigned CP      = unsigned'(CLOCK_MHZ * PERIOD_NS / 1000);
  localparam int unsigned CH0     = unsigned'(CLOCK_MHZ * T0H_NS / 1000);
  localparam int unsigned CH1     = unsigned'(CLOCK_MHZ * T1H_NS / 1000);
  localparam int unsigned CR      = unsigned'(CLOCK_MHZ * RESET_US);
  localparam int unsigned CNT_MAX = (CR > CP) ? CR : CP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned PW      = $clog2(BITS);
  localparam int unsigned EW      = BITS + 9;

  localparam logic [CW-1:0] CP_M1   = CW'(CP - 1);
  localparam logic [CW-1:0] CH0_M1  = CW'(CH0 - 1);
  localparam logic [CW-1:0] CH1_M1  = CW'(CH1 - 1);
  localparam logic [CW-1:0] CR_C    = CW'(CR);
  localparam logic [PW-1:0] TOP_BIT = PW'(BITS - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   bitpos_q, bitpos_d;
  logic [BITS-1:0] pix_q, pix_d;
  logic [7:0]      rpt_q, rpt_d;
  logic            lat_q, lat_d;
  logic            led_q, led_d;

  logic            push_c;
  logic            pop_c;
  logic            empty_c;
  logic [EW-1:0]   head_c;
  logic [CW-1:0]   hi_end_c;
  logic            bit_end_c;
  logic            pixel_end_c;

  assign push_c      = valid && ready;
  assign empty_c     = (level_q == '0);
  assign head_c      = mem_q[rd_ptr_q];
  assign hi_end_c    = pix_q[bitpos_q] ? CH1_M1 : CH0_M1;
  assign bit_end_c   = (cnt_q == CP_M1);
  assign pixel_end_c = bit_end_c && (bitpos_q == '0) && (rpt_q == '0);

  assign ready = (level_q < DEPTH_L);
  assign level = level_q;
  assign busy  = (state_q != S_IDLE) || !empty_c;
  assign led   = led_q;

  // Entry storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {data_in, repeat_in, latch};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Reset lands in LATCH so the strip always sees a full latch pulse first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LATCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (pixel_end_c) begin
          if (lat_q) begin
            state_d = S_LATCH;
          end else if (empty_c) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (cnt_q >= CR_C) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Bit timing, repeat/latch sequencing and FIFO pop decisions.
  always_comb begin
    cnt_d    = cnt_q;
    bitpos_d = bitpos_q;
    pix_d    = pix_q;
    rpt_d    = rpt_q;
    lat_d    = lat_q;
    led_d    = led_q;
    pop_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        led_d = 1'b0;
        if (!empty_c) begin
          pop_c = 1'b1;
        end
      end
      S_SEND: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bitpos_q != '0) begin
            bitpos_d = bitpos_q - PW'(1);
            led_d    = 1'b1;
          end else if (rpt_q != '0) begin
            rpt_d    = rpt_q - 8'd1;
            bitpos_d = TOP_BIT;
            led_d    = 1'b1;
          end else if (!lat_q && !empty_c) begin
            pop_c = 1'b1;
          end else begin
            led_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == hi_end_c) begin
            led_d = 1'b0;
          end
        end
      end
      default: begin
        led_d = 1'b0;
        cnt_d = (cnt_q >= CR_C) ? '0 : cnt_q + CW'(1);
      end
    endcase
    // A pop always starts a fresh pixel on the next cycle.
    if (pop_c) begin
      pix_d    = head_c[EW-1 -: BITS];
      rpt_d    = head_c[8:1];
      lat_d    = head_c[0];
      bitpos_d = TOP_BIT;
      cnt_d    = '0;
      led_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      bitpos_q <= '0;
      pix_q    <= '0;
      rpt_q    <= '0;
      lat_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bitpos_q <= bitpos_d;
      pix_q    <= pix_d;
      rpt_q    <= rpt_d;
      lat_q    <= lat_d;
      led_q    <= led_d;
    end
  end

endmodule

// File: tb/tb_ws281x_stream.sv
// Self-checking bench for ws281x_stream: a 24-bit and a 32-bit instance are
// driven and their led waveforms decoded back into bits against a pixel queue.
module tb_ws281x_stream;

  localparam int CLOCK_MHZ = 64;
  localparam int RESET_US  = 2;
  localparam int DEPTH     = 4;
  localparam int CP        = CLOCK_MHZ * 1250 / 1000;
  localparam int CH0       = CLOCK_MHZ * 400 / 1000;
  localparam int CH1       = CLOCK_MHZ * 800 / 1000;
  localparam int CR        = CLOCK_MHZ * RESET_US;
  localparam int LIM       = 5000;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  r;
    logic        l;
  } pix_t;

  typedef struct {
    logic        sel;
    logic [31:0] d;
    logic [7:0]  r;
    logic        l;
    int          ones;
    int          periods;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [7:0]  rpt_in;
  logic        lat_in;
  logic        valid24, valid32;
  logic        ready24, ready32;
  logic [2:0]  level24, level32;
  logic        busy24, busy32;
  logic        led24, led32;
  logic        sel32;

  int checks = 0;
  int errors = 0;
  pix_t exp_q[$];
  vec_t vecs[7];

  wire       mon_led   = sel32 ? led32 : led24;
  wire       mon_ready = sel32 ? ready32 : ready24;
  wire       mon_busy  = sel32 ? busy32 : busy24;
  wire [2:0] mon_level = sel32 ? level32 : level24;

  ws281x_stream #(.CLOCK_MHZ(CLOCK_MHZ), .BITS(24), .DEPTH(DEPTH), .RESET_US(RESET_US)) dut24 (
    .clk(clk), .reset(rst), .data_in(din[23:0]), .repeat_in(rpt_in), .latch(lat_in),
    .valid(valid24), .ready(ready24), .level(level24), .busy(busy24), .led(led24)
  );

  ws281x_stream #(.CLOCK_MHZ(CLOCK_MHZ), .BITS(32), .DEPTH(DEPTH), .RESET_US(RESET_US)) dut32 (
    .clk(clk), .reset(rst), .data_in(din), .repeat_in(rpt_in), .latch(lat_in),
    .valid(valid32), .ready(ready32), .level(level32), .busy(busy32), .led(led32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_ge(input string name, input longint act, input longint lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
    end
  endfunction

  task automatic sample(output logic v);
    @(negedge clk);
    v = mon_led;
  endtask

  // Offer one entry until accepted; the model queue records it in push order.
  task automatic push(input logic [31:0] d, input logic [7:0] r, input logic l);
    int w;
    pix_t p;
    @(negedge clk);
    din = d; rpt_in = r; lat_in = l;
    if (sel32) valid32 = 1'b1; else valid24 = 1'b1;
    w = 0;
    while (!mon_ready && w < LIM) begin
      @(negedge clk);
      w++;
    end
    check("push_accept", w < LIM, 1);
    p.d = d; p.r = r; p.l = l;
    if (w < LIM) exp_q.push_back(p);
    @(negedge clk);
    valid24 = 1'b0;
    valid32 = 1'b0;
  endtask

  // Decode one bit period: low samples before the rise, high length, and a low tail filling CP.
  task automatic get_bit(input int max_gap, output int gap, output int h, output bit ok);
    logic v;
    int l;
    gap = 0; h = 0; ok = 1'b0;
    sample(v);
    while (v !== 1'b1) begin
      if (gap >= max_gap) return;
      gap++;
      sample(v);
    end
    while (v === 1'b1) begin
      h++;
      if (h > CP) return;
      sample(v);
    end
    l = 1;
    while (h + l < CP) begin
      sample(v);
      if (v === 1'b1) return;
      l++;
    end
    ok = 1'b1;
  endtask

  task automatic check_pixel(input string tag, input int max_gap, output int first_gap,
                             output bit lat, output int ones, output int periods, output bit ok);
    pix_t p;
    int gap, h, nbits, total, exp_h;
    bit bok;
    ok = 1'b0; lat = 1'b0; ones = 0; periods = 0; first_gap = 0;
    nbits = sel32 ? 32 : 24;
    get_bit(max_gap, gap, h, bok);
    check({tag, "_first_bit"}, bok, 1);
    if (!bok) return;
    first_gap = gap;
    check({tag, "_model_pixel"}, exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    p = exp_q.pop_front();
    lat = p.l;
    total = (int'(p.r) + 1) * nbits;
    for (int k = 0; k < total; k++) begin
      if (k > 0) begin
        get_bit(CP, gap, h, bok);
        check({tag, "_bit_found"}, bok, 1);
        if (!bok) return;
        check({tag, "_gap"}, gap, 0);
      end
      exp_h = p.d[nbits - 1 - (k % nbits)] ? CH1 : CH0;
      check({tag, "_high"}, h, exp_h);
      periods++;
      if (h == CH1) ones++;
    end
    ok = 1'b1;
  endtask

  // Cycles busy stays high after the current point, and led highs seen meanwhile.
  task automatic count_busy(output int n, output int hi);
    bit done;
    n = 0; hi = 0; done = 1'b0;
    while (!done && n < 4 * CR) begin
      @(negedge clk);
      if (mon_busy) begin
        n++;
        if (mon_led) hi++;
      end else begin
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int fg, ones, per, n, hi, nrand;
    bit lat, ok, prev_lat;
    logic [31:0] ffd[5];
    pix_t p;

    vecs[0] = '{1'b0, 32'h00FF0000, 8'd0, 1'b0, 8, 24};
    vecs[1] = '{1'b0, 32'h00000001, 8'd2, 1'b1, 3, 72};
    vecs[2] = '{1'b0, 32'h00A5A5A5, 8'd0, 1'b1, 12, 24};
    vecs[3] = '{1'b0, 32'h00000000, 8'd1, 1'b0, 0, 48};
    vecs[4] = '{1'b1, 32'h80000001, 8'd0, 1'b0, 2, 32};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 8'd0, 1'b1, 32, 32};
    vecs[6] = '{1'b0, 32'h00800000, 8'd0, 1'b1, 1, 24};
    ffd = '{32'h00F00000, 32'h000F0000, 32'h0000F000, 32'h00000F00, 32'h00FFFFFF};

    rst = 1'b1; din = '0; rpt_in = '0; lat_in = 1'b0;
    valid24 = 1'b0; valid32 = 1'b0; sel32 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_led24", led24, 0);
    check("rst_level24", level24, 0);
    check("rst_ready24", ready24, 1);
    check("rst_busy24", busy24, 1);
    check("rst_led32", led32, 0);
    check("rst_level32", level32, 0);
    check("rst_ready32", ready32, 1);
    check("rst_busy32", busy32, 1);

    // Post-reset: LATCH spans the release cycle plus CR sampled cycles, then one IDLE cycle pops.
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fork
      push(32'h00FF0000, 8'd0, 1'b0);
      check_pixel("postrst", LIM, fg, lat, ones, per, ok);
    join
    check("postrst_low_cycles", fg, CR + 1);
    check("postrst_ones", ones, 8);
    count_busy(n, hi);
    check("postrst_busy_tail", n, 0);

    // Table vectors from idle: one cycle to accept, one IDLE cycle to pop, then the pixel.
    for (int i = 0; i < 7; i++) begin
      sel32 = vecs[i].sel;
      exp_q.delete();
      fork
        push(vecs[i].d, vecs[i].r, vecs[i].l);
        check_pixel("vec", LIM, fg, lat, ones, per, ok);
      join
      check("vec_start_gap", fg, 2);
      check("vec_ones", ones, vecs[i].ones);
      check("vec_periods", per, vecs[i].periods);
      count_busy(n, hi);
      check("vec_latch_len", n, vecs[i].l ? CR + 1 : 0);
      check("vec_latch_led", hi, 0);
    end
    sel32 = 1'b0;

    // Back-to-back pixels, latch only on the third.
    exp_q.delete();
    fork
      begin
        push(32'h00123456, 8'd0, 1'b0);
        push(32'h00ABCDEF, 8'd0, 1'b0);
        push(32'h00F0F00F, 8'd0, 1'b1);
      end
      begin
        check_pixel("b2b", LIM, fg, lat, ones, per, ok);
        for (int j = 0; j < 2; j++) begin
          check_pixel("b2b", LIM, fg, lat, ones, per, ok);
          check("b2b_pixel_gap", fg, 0);
        end
        check("b2b_latch_flag", lat, 1);
      end
    join
    count_busy(n, hi);
    check("b2b_latch_len", n, CR + 1);

    // Fill the FIFO during the post-reset latch; the fifth offer must be dropped.
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_level", mon_level, (k < 4) ? k : 4);
      check("full_ready", mon_ready, (k < 4) ? 1 : 0);
      din = ffd[k]; rpt_in = 8'd0; lat_in = (k >= 3); valid24 = 1'b1;
      if (k < 4) begin
        p.d = ffd[k]; p.r = 8'd0; p.l = (k >= 3);
        exp_q.push_back(p);
      end
    end
    @(negedge clk);
    check("full_level_after", mon_level, 4);
    check("full_ready_after", mon_ready, 0);
    valid24 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_pixel("full", LIM, fg, lat, ones, per, ok);
      if (j > 0) check("full_pixel_gap", fg, 0);
    end
    count_busy(n, hi);
    check("full_latch_len", n, CR + 1);
    check("full_level_end", mon_level, 0);
    hi = 0;
    repeat (2 * CP) begin
      @(negedge clk);
      if (mon_led) hi++;
    end
    check("full_no_fifth", hi, 0);

    // Asynchronous reset while led is high with two pixels still queued.
    exp_q.delete();
    push(32'h00FF00FF, 8'd0, 1'b0);
    push(32'h0000FF00, 8'd0, 1'b0);
    push(32'h000000FF, 8'd0, 1'b1);
    check("async_pre_led", mon_led, 1);
    check("async_pre_level", mon_level, 2);
    #2 rst = 1'b1;
    #1;
    check("async_led", led24, 0);
    check("async_level", level24, 0);
    check("async_ready", ready24, 1);
    check("async_busy", busy24, 1);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    count_busy(n, hi);
    check("async_latch_len", n, CR);
    check("async_latch_led", hi, 0);
    check("async_level_end", mon_level, 0);

    // Randomized stream against the pixel queue; after a latch the line stays low at least CR+2 samples.
    exp_q.delete();
    nrand = 8;
    fork
      begin
        for (int i = 0; i < nrand; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push($urandom, 8'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
      end
      begin
        prev_lat = 1'b0;
        for (int i = 0; i < nrand; i++) begin
          check_pixel("rand", LIM, fg, lat, ones, per, ok);
          if (!ok) break;
          if (prev_lat) check_ge("rand_latch_gap", fg, CR + 2);
          prev_lat = lat;
        end
      end
    join
    count_busy(n, hi);
    check("rand_tail", n, prev_lat ? CR + 1 : 0);
    check("rand_level_end", mon_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
